uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Controller between uart_rx and the register/stream side of the UART peripheral. It owns the receiver's prescale configuration and runs the rx_ready/rx_ack handshake. Received bytes go into a local FIFO drained over a valid/ready stream. It also keeps sticky status and saturating error counters for the AXI-Lite register block.

Parameters:
DATA_WIDTH, 8, receiver data width; must equal the uart_rx DATA_WIDTH.
FIFO_DEPTH, 16, receive FIFO entries; power of 2, minimum 2.
CNT_WIDTH, 8, width of the saturating error counters.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
enable  in  1  1 = drain the receiver; 0 = leave rx_ready pending, never ack
cfg_prescale  in  16  requested clocks per bit
cfg_wr  in  1  one-cycle strobe; latches cfg_prescale as pending
flush  in  1  one-cycle strobe; empties the FIFO
clr_status  in  1  one-cycle strobe; clears sticky flags and counters
prescale  out  16  prescale driven to uart_rx
rx_data  in  DATA_WIDTH  byte from uart_rx
rx_ready  in  1  uart_rx byte-available flag
rx_ack  out  1  acknowledge to uart_rx
rx_busy  in  1  uart_rx busy
rx_overrun  in  1  uart_rx overrun_error
rx_framing  in  1  uart_rx framing_error
m_data  out  DATA_WIDTH  FIFO head byte
m_valid  out  1  FIFO not empty
m_ready  in  1  consumer accepts the head byte
fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
fifo_ovf  out  1  sticky; a byte was dropped because the FIFO was full
rx_ovr_seen  out  1  sticky copy of rx_overrun
frame_err_cnt  out  CNT_WIDTH  saturating count of framing errors
drop_cnt  out  CNT_WIDTH  saturating count of dropped bytes

Behaviour:
- Reset values: prescale=16'd868; rx_ack=0; m_valid=0; fifo_level=0; all sticky flags and counters=0; pending cleared; FSM in HS_IDLE.
- Prescale config:
  - On cfg_wr, store max(cfg_prescale, 4) as the pending value.
  - Apply it to prescale on the first cycle with rx_busy==0, then clear pending. Application can be the same cycle as cfg_wr if rx_busy==0.
  - prescale never changes while rx_busy==1.
  - A cfg_wr while a value is pending overwrites the pending value.
- Handshake FSM (rx_ack is registered, high only in HS_ACK):
  - HS_IDLE: go to HS_ACK when enable && rx_ready. In that same cycle:
    - if FIFO not full, push rx_data;
    - if FIFO full, drop the byte, set fifo_ovf and increment drop_cnt.
  - HS_ACK: rx_ack=1 for exactly one cycle, then go to HS_WAIT.
  - HS_WAIT: return to HS_IDLE when rx_ready==0. Guarantees exactly one push per received byte.
  - enable deasserted mid-handshake does not abort it; only HS_IDLE honours enable.
- FIFO:
  - Show-ahead; m_data is valid whenever m_valid=1.
  - Pop on m_valid && m_ready.
  - Push and pop in the same cycle while full: pop is performed, push is accepted, no drop.
  - Push and pop in the same cycle while empty: byte stored, level becomes 1 (no bypass).
  - Pointers wrap modulo FIFO_DEPTH; fifo_level = write count minus read count, width log2(FIFO_DEPTH)+1.
  - flush zeroes the pointers next cycle and wins over a simultaneous push or pop. The handshake still completes; the flushed-cycle byte is lost without counting as a drop.
- Framing errors:
  - On an rx_busy falling edge (previous 1, current 0) with rx_framing==1, increment frame_err_cnt.
  - Known and accepted: a false start immediately after a framing-error frame is also counted.
- rx_ovr_seen is set while rx_overrun==1.
- Counters saturate at all-ones.
- clr_status clears sticky flags and counters; an event in the same cycle wins and leaves flag=1 / counter=1.

Decomposition:
- Package uart_pkg: handshake state encoding (HS_IDLE/HS_ACK/HS_WAIT), PRESCALE_MIN=4, PRESCALE_RST=868.
- One sub-module: uart_sync_fifo (parameterised DATA_WIDTH/DEPTH, show-ahead, level output, flush). Also reusable by the TX path.

Test Plan:
- Reset, then uart_rx receives 0xA5 at prescale 16 -> one rx_ack pulse; m_valid=1, m_data=0xA5, fifo_level=1.
- m_ready held low, 17 bytes sent -> fifo_level=16; 17th byte dropped; fifo_ovf=1, drop_cnt=1; rx_ack still pulses 17 times.
- cfg_wr with 8 mid-frame (rx_busy=1) -> prescale unchanged until busy drops, then 8. cfg_wr with 2 -> prescale=4.
- Frame with stop bit low -> frame_err_cnt=1, no FIFO push. A following good 0x3C is pushed normally.
- enable=0 while two bytes arrive -> no rx_ack, rx_ovr_seen=1. enable=1 -> the second byte (0x3C) is pushed, single ack.
- clr_status in the same cycle as a drop -> drop_cnt=1, fifo_ovf=1. flush with level 5 -> level 0 next cycle, m_valid=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: handshake state encoding and prescale limits/reset value.
// Pure declarations; no timing or flow-control behaviour of its own.
package uart_pkg;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_ACK  = 2'd1,
    HS_WAIT = 2'd2
  } hs_state_t;

  localparam logic [15:0] PRESCALE_MIN = 16'd4;
  localparam logic [15:0] PRESCALE_RST = 16'd868;

  function automatic logic [15:0] clamp_prescale(input logic [15:0] p);
    return (p < PRESCALE_MIN) ? PRESCALE_MIN : p;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output and flush; write-to-read latency 1 cycle.
// Push is refused only when full without a simultaneous pop; flush wins over push and pop.
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  empty,
  output logic                  full,
  output logic [AW:0]           level
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // One extra pointer bit lets full and empty be told apart by the difference alone.
  assign level     = wr_ptr - rd_ptr;
  assign empty     = (level == '0);
  assign full      = (level == (AW + 1)'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: prescale config, rx_ready/rx_ack handshake, RX FIFO, sticky status.
// Byte visible on m_valid one cycle after capture; full FIFO drops and counts, never stalls uart_rx.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 8,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [15:0]           cfg_prescale,
  input  logic                  cfg_wr,
  input  logic                  flush,
  input  logic                  clr_status,
  output logic [15:0]           prescale,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_ready,
  output logic                  rx_ack,
  input  logic                  rx_busy,
  input  logic                  rx_overrun,
  input  logic                  rx_framing,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  fifo_ovf,
  output logic                  rx_ovr_seen,
  output logic [CNT_WIDTH-1:0]  frame_err_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  hs_state_t   state;
  logic        take;
  logic        push;
  logic        pop;
  logic        drop;
  logic        fifo_empty;
  logic        fifo_full;
  logic        busy_q;
  logic        frame_evt;
  logic        pend_vld;
  logic [15:0] pend_val;
  logic [15:0] cfg_clamped;
  logic [15:0] pend_sel;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  // The byte is captured in the IDLE cycle that accepts it; ACK/WAIT only finish the handshake.
  assign take      = (state == HS_IDLE) && enable && rx_ready;
  assign pop       = m_valid && m_ready;
  assign push      = take && !flush;
  assign drop      = take && fifo_full && !pop && !flush;
  assign m_valid   = !fifo_empty;
  assign frame_evt = busy_q && !rx_busy && rx_framing;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (rx_data),
    .pop       (pop),
    .head_data (m_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= HS_IDLE;
      rx_ack <= 1'b0;
    end else begin
      case (state)
        HS_IDLE: begin
          rx_ack <= take;
          if (take) state <= HS_ACK;
        end
        HS_ACK: begin
          rx_ack <= 1'b0;
          state  <= HS_WAIT;
        end
        HS_WAIT: begin
          rx_ack <= 1'b0;
          if (!rx_ready) state <= HS_IDLE;
        end
        default: begin
          rx_ack <= 1'b0;
          state  <= HS_IDLE;
        end
      endcase
    end
  end

  // A fresh cfg_wr takes priority over an older pending value, even in the cycle it applies.
  assign cfg_clamped = clamp_prescale(cfg_prescale);
  assign pend_sel    = cfg_wr ? cfg_clamped : pend_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= PRESCALE_RST;
      pend_vld <= 1'b0;
      pend_val <= PRESCALE_RST;
    end else if ((cfg_wr || pend_vld) && !rx_busy) begin
      prescale <= pend_sel;
      pend_vld <= 1'b0;
    end else if (cfg_wr) begin
      pend_vld <= 1'b1;
      pend_val <= cfg_clamped;
    end
  end

  // Events coinciding with clr_status survive the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= 1'b0;
      fifo_ovf      <= 1'b0;
      rx_ovr_seen   <= 1'b0;
      frame_err_cnt <= '0;
      drop_cnt      <= '0;
    end else begin
      busy_q      <= rx_busy;
      fifo_ovf    <= drop | (fifo_ovf & ~clr_status);
      rx_ovr_seen <= rx_overrun | (rx_ovr_seen & ~clr_status);
      if (clr_status) begin
        frame_err_cnt <= CNT_WIDTH'(frame_evt);
        drop_cnt      <= CNT_WIDTH'(drop);
      end else begin
        if (frame_evt) frame_err_cnt <= sat_inc(frame_err_cnt);
        if (drop)      drop_cnt      <= sat_inc(drop_cnt);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: per-cycle vector table plus hand sequences for FIFO/status corners.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] cfg_prescale;
  logic        cfg_wr;
  logic        flush;
  logic        clr_status;
  logic [15:0] prescale;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_ack;
  logic        rx_busy;
  logic        rx_overrun;
  logic        rx_framing;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  fifo_level;
  logic        fifo_ovf;
  logic        rx_ovr_seen;
  logic [7:0]  frame_err_cnt;
  logic [7:0]  drop_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int ack_pulses;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .cfg_prescale  (cfg_prescale),
    .cfg_wr        (cfg_wr),
    .flush         (flush),
    .clr_status    (clr_status),
    .prescale      (prescale),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .rx_ack        (rx_ack),
    .rx_busy       (rx_busy),
    .rx_overrun    (rx_overrun),
    .rx_framing    (rx_framing),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .fifo_level    (fifo_level),
    .fifo_ovf      (fifo_ovf),
    .rx_ovr_seen   (rx_ovr_seen),
    .frame_err_cnt (frame_err_cnt),
    .drop_cnt      (drop_cnt)
  );

  typedef struct packed {
    logic        en;
    logic        rdy;
    logic [7:0]  dat;
    logic        mrdy;
    logic        busy;
    logic        ovr;
    logic        frm;
    logic        cw;
    logic [15:0] cfg;
    logic        clr;
    logic        xack;
    logic        xval;
    logic [7:0]  xdat;
    logic [4:0]  xlvl;
    logic [15:0] xpre;
    logic        xovf;
    logic        xovr;
    logic [7:0]  xfe;
    logic [7:0]  xdrop;
  } vec_t;

  vec_t tbl [24];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Plays the uart_rx side: raise rx_ready, wait for the ack, then withdraw it.
  task automatic send_byte(input logic [7:0] d);
    bit got;
    got      = 1'b0;
    rx_data  = d;
    rx_ready = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (rx_ack) begin
        got = 1'b1;
        ack_pulses++;
      end
    end
    chk("ack_seen", 64'(got), 64'd1);
    rx_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (rx_ack) ack_pulses++;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // en rdy dat mrdy busy ovr frm cw cfg clr | ack val dat lvl pre ovf ovr fe drop
    tbl[0]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,1'b0, 1'b0,1'b0,8'h00,5'd0,16'd868,1'b0,1'b0,8'd0,8'd0};
    tbl[1]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b1,16'd16,1'b0, 1'b0,1'b0,8'h00,5'd0,16'd16,1'b0,1'b0,8'd0,8'd0};
    tbl[2]  = '{1'b1,1'b1,8'hA5,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,1'b0, 1'b1,1'b1,8'hA5,5'd1,16'd16,1'b0,1'b0,8'd0,8'd0};
    tbl[3]  = '{1'b1,1'b1,8'hA5,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,1'b0, 1'b0,1'b1,8'hA5,5'd1,16'd16,1'b0,1'b0,8'd0,8'd0};
    tbl[4]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,1'b0, 1'b0,1'b1,8'hA5,5'd1,16'd16,1'b0,1'b0,8'd0,8'd0};
    tbl[5]  = '{1'b1,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0,1'b1,16'd8,1'b0, 1'b0,1'b1,8'hA5,5'd1,16'd16,1'b0,1'b0,8'd0,8'd0};
    tbl[6]  = '{1'b1,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,1'b0, 1'b0,1'b1,8'hA5,5'd1,16'd16,1'b0,1'b0,8'd0,8'd0};
    tbl[7]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,1'b0, 1'b0,1'b1,8'hA5,5'd1,16'd8,1'b0,1'b0,8'd0,8'd0};
    tbl[8]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b1,16'd2,1'b0, 1'b0,1'b1,8'hA5,5'd1,16'd4,1'b0,1'b0,8'd0,8'd0};
    tbl[9]  = '{1'b1,1'b0,8'h00,1'b0,1'b1,1'b0,1'b1,1'b0,16'd0,1'b0, 1'b0,1'b1,8'hA5,5'd1,16'd4,1'b0,1'b0,8'd0,8'd0};
    tbl[10] = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b1,1'b0,16'd0,1'b0, 1'b0,1'b1,8'hA5,5'd1,16'd4,1'b0,1'b0,8'd1,8'd0};
    tbl[11] = '{1'b1,1'b1,8'h3C,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,1'b0, 1'b1,1'b1,8'hA5,5'd2,16'd4,1'b0,1'b0,8'd1,8'd0};
    tbl[12] = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,1'b0, 1'b0,1'b1,8'hA5,5'd2,16'd4,1'b0,1'b0,8'd1,8'd0};
    tbl[13] = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,1'b0, 1'b0,1'b1,8'hA5,5'd2,16'd4,1'b0,1'b0,8'd1,8'd0};
    tbl[14] = '{1'b1,1'b0,8'h00,1'b1,1'b0,1'b0,1'b0,1'b0,16'd0,1'b0, 1'b0,1'b1,8'h3C,5'd1,16'd4,1'b0,1'b0,8'd1,8'd0};
    tbl[15] = '{1'b1,1'b0,8'h00,1'b1,1'b0,1'b0,1'b0,1'b0,16'd0,1'b0, 1'b0,1'b0,8'h00,5'd0,16'd4,1'b0,1'b0,8'd1,8'd0};
    tbl[16] = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0,16'd0,1'b0, 1'b0,1'b0,8'h00,5'd0,16'd4,1'b0,1'b1,8'd1,8'd0};
    tbl[17] = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,1'b1, 1'b0,1'b0,8'h00,5'd0,16'd4,1'b0,1'b0,8'd0,8'd0};
    tbl[18] = '{1'b0,1'b1,8'h11,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,1'b0, 1'b0,1'b0,8'h00,5'd0,16'd4,1'b0,1'b0,8'd0,8'd0};
    tbl[19] = '{1'b0,1'b1,8'h3C,1'b0,1'b0,1'b1,1'b0,1'b0,16'd0,1'b0, 1'b0,1'b0,8'h00,5'd0,16'd4,1'b0,1'b1,8'd0,8'd0};
    tbl[20] = '{1'b1,1'b1,8'h3C,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,1'b0, 1'b1,1'b1,8'h3C,5'd1,16'd4,1'b0,1'b1,8'd0,8'd0};
    tbl[21] = '{1'b0,1'b1,8'h3C,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,1'b0, 1'b0,1'b1,8'h3C,5'd1,16'd4,1'b0,1'b1,8'd0,8'd0};
    tbl[22] = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,1'b0, 1'b0,1'b1,8'h3C,5'd1,16'd4,1'b0,1'b1,8'd0,8'd0};
    tbl[23] = '{1'b1,1'b0,8'h00,1'b1,1'b0,1'b0,1'b0,1'b0,16'd0,1'b0, 1'b0,1'b0,8'h00,5'd0,16'd4,1'b0,1'b1,8'd0,8'd0};

    rst = 1'b1; enable = 1'b0; cfg_prescale = 16'd0; cfg_wr = 1'b0; flush = 1'b0;
    clr_status = 1'b0; rx_data = 8'h00; rx_ready = 1'b0; rx_busy = 1'b0;
    rx_overrun = 1'b0; rx_framing = 1'b0; m_ready = 1'b0;
    ack_pulses = 0;
    repeat (3) tick();
    chk("reset_state",
        64'({rx_ack, m_valid, fifo_level, prescale, fifo_ovf, rx_ovr_seen, frame_err_cnt, drop_cnt}),
        64'({1'b0, 1'b0, 5'd0, 16'd868, 1'b0, 1'b0, 8'd0, 8'd0}));
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      enable = tbl[i].en;  rx_ready = tbl[i].rdy; rx_data = tbl[i].dat; m_ready = tbl[i].mrdy;
      rx_busy = tbl[i].busy; rx_overrun = tbl[i].ovr; rx_framing = tbl[i].frm;
      cfg_wr = tbl[i].cw; cfg_prescale = tbl[i].cfg; clr_status = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d", i),
          64'({rx_ack, m_valid, (m_valid ? m_data : 8'h00), fifo_level, prescale,
               fifo_ovf, rx_ovr_seen, frame_err_cnt, drop_cnt}),
          64'({tbl[i].xack, tbl[i].xval, (tbl[i].xval ? tbl[i].xdat : 8'h00), tbl[i].xlvl,
               tbl[i].xpre, tbl[i].xovf, tbl[i].xovr, tbl[i].xfe, tbl[i].xdrop}));
    end
    enable = 1'b1; rx_ready = 1'b0; m_ready = 1'b0; rx_busy = 1'b0;
    rx_overrun = 1'b0; rx_framing = 1'b0; cfg_wr = 1'b0; clr_status = 1'b0;

    // 17 bytes into a 16-deep FIFO with the consumer stalled.
    ack_pulses = 0;
    for (int i = 0; i < 17; i++) send_byte(8'h40 + 8'(i));
    chk("fill_ack_pulses", 64'(ack_pulses), 64'd17);
    chk("fill_level_ovf_drop", 64'({fifo_level, fifo_ovf, drop_cnt}), 64'({5'd16, 1'b1, 8'd1}));
    send_byte(8'h51);
    chk("second_drop", 64'(drop_cnt), 64'd2);

    // Clear coinciding with a drop leaves counter at 1 and flag set.
    rx_data = 8'hEE; rx_ready = 1'b1; clr_status = 1'b1;
    tick();
    clr_status = 1'b0; rx_ready = 1'b0;
    chk("clr_with_drop", 64'({fifo_ovf, rx_ovr_seen, drop_cnt}), 64'({1'b1, 1'b0, 8'd1}));
    tick(); tick();

    // Push and pop together while full: no drop, head advances.
    rx_data = 8'h99; rx_ready = 1'b1; m_ready = 1'b1;
    tick();
    m_ready = 1'b0; rx_ready = 1'b0;
    chk("full_push_pop", 64'({fifo_level, drop_cnt, m_data}), 64'({5'd16, 8'd1, 8'h41}));
    tick(); tick();

    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_d;
      exp_d = (i < 15) ? 8'h41 + 8'(i) : 8'h99;
      chk($sformatf("drain%0d", i), 64'({m_valid, m_data}), 64'({1'b1, exp_d}));
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
    chk("drained", 64'({m_valid, fifo_level}), 64'({1'b0, 5'd0}));

    // Push and pop together while empty: stored, no bypass.
    rx_data = 8'h5A; rx_ready = 1'b1; m_ready = 1'b1;
    tick();
    m_ready = 1'b0; rx_ready = 1'b0;
    chk("empty_push_pop", 64'({m_valid, m_data, fifo_level}), 64'({1'b1, 8'h5A, 5'd1}));
    tick(); tick();

    for (int i = 0; i < 4; i++) send_byte(8'h60 + 8'(i));
    chk("level5", 64'(fifo_level), 64'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_level5", 64'({m_valid, fifo_level}), 64'({1'b0, 5'd0}));

    // Flush with a simultaneous capture: byte lost, not counted, ack still given.
    rx_data = 8'h77; rx_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; rx_ready = 1'b0;
    chk("flush_vs_push", 64'({rx_ack, fifo_level, drop_cnt}), 64'({1'b1, 5'd0, 8'd1}));
    tick(); tick();
    chk("flush_vs_push_after", 64'({rx_ack, m_valid, fifo_level}), 64'({1'b0, 1'b0, 5'd0}));

    // Framing counter saturation, then clear with a simultaneous event.
    rx_framing = 1'b1;
    for (int i = 0; i < 260; i++) begin
      rx_busy = 1'b1; tick();
      rx_busy = 1'b0; tick();
    end
    chk("frame_sat", 64'(frame_err_cnt), 64'd255);
    rx_busy = 1'b1; tick();
    rx_busy = 1'b0; clr_status = 1'b1; tick();
    clr_status = 1'b0; rx_framing = 1'b0;
    chk("frame_clr_evt", 64'({frame_err_cnt, drop_cnt, fifo_ovf}), 64'({8'd1, 8'd0, 1'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
